// File: rtl/grf_wb_arb.sv
// GRF writeback arbiter: W stage first, then buffered late results, else late bypass; 1-cycle registered write port.
// Late results back-pressured by md_ready = (count < DEPTH); optional write trace under GRF_WB_TRACE_EN.
module grf_wb_arb #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_valid,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  input  logic [31:0] w_pc,
  input  logic        md_valid,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  input  logic [31:0] md_pc,
  output logic        md_ready,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        pend_hit,
  output logic        reg_write,
  output logic [4:0]  reg_addr,
  output logic [31:0] reg_data,
  output logic [31:0] reg_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]       buf_addr [DEPTH];
  logic [31:0]      buf_data [DEPTH];
  logic [31:0]      buf_pc   [DEPTH];
  logic [DEPTH-1:0] buf_vld;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic w_grant;
  logic md_live;
  logic buf_empty;
  logic head_vld;
  logic pop;
  logic pop_out;
  logic bypass;
  logic push;
  logic push_vld;

  assign md_ready  = (count < CW'(DEPTH));
  assign w_grant   = w_valid && (w_addr != 5'd0);
  assign md_live   = md_valid && md_ready && (md_addr != 5'd0);
  assign buf_empty = (count == '0);
  assign head_vld  = buf_vld[rd_ptr];
  // A squashed head is dropped even while W owns the write port.
  assign pop       = !buf_empty && (!head_vld || !w_grant);
  assign pop_out   = pop && head_vld;
  assign bypass    = md_live && buf_empty && !w_grant;
  assign push      = md_live && !bypass;
  assign push_vld  = !(w_grant && (w_addr == md_addr));

  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr] <= md_addr;
      buf_data[wr_ptr] <= md_data;
      buf_pc[wr_ptr]   <= md_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write <= 1'b0;
      reg_addr  <= '0;
      reg_data  <= '0;
      reg_pc    <= '0;
      buf_vld   <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      reg_write <= 1'b0;
      if (w_grant) begin
        reg_write <= 1'b1;
        reg_addr  <= w_addr;
        reg_data  <= w_data;
        reg_pc    <= w_pc;
      end else if (pop_out) begin
        reg_write <= 1'b1;
        reg_addr  <= buf_addr[rd_ptr];
        reg_data  <= buf_data[rd_ptr];
        reg_pc    <= buf_pc[rd_ptr];
      end else if (bypass) begin
        reg_write <= 1'b1;
        reg_addr  <= md_addr;
        reg_data  <= md_data;
        reg_pc    <= md_pc;
      end

      // W is younger than anything buffered, so matching entries are stale.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_grant && (buf_addr[i] == w_addr)) buf_vld[i] <= 1'b0;
      end
      if (pop) begin
        buf_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      if (push) begin
        buf_vld[wr_ptr] <= push_vld;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (buf_vld[i] && (buf_addr[i] != 5'd0) &&
          (((rs_addr != 5'd0) && (buf_addr[i] == rs_addr)) ||
           ((rt_addr != 5'd0) && (buf_addr[i] == rt_addr))))
        pend_hit = 1'b1;
    end
  end

`ifdef GRF_WB_TRACE_EN
  always @(posedge clk) begin
    if (reg_write) $display("@%h: $%0d <= %h", reg_pc, reg_addr, reg_data);
  end
`else
  // trace printing compiled out
`endif

endmodule

// File: tb/tb_grf_wb_arb.sv
// Directed bench for grf_wb_arb: scoreboard of expected GRF writes plus point checks of handshake/hazard outputs.
module tb_grf_wb_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_valid;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] w_pc;
  logic        md_valid;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic [31:0] md_pc;
  logic        md_ready;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        pend_hit;
  logic        reg_write;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [31:0] reg_pc;

  grf_wb_arb #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data), .w_pc(w_pc),
    .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_pc(md_pc),
    .md_ready(md_ready), .rs_addr(rs_addr), .rt_addr(rt_addr), .pend_hit(pend_hit),
    .reg_write(reg_write), .reg_addr(reg_addr), .reg_data(reg_data), .reg_pc(reg_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  logic [4:0] col_addr [5] = '{5'd9, 5'd10, 5'd11, 5'd11, 5'd11};
  logic       col_rdy  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       col_hit  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_valid  = 1'b0;
    md_valid = 1'b0;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    wr_t e;
    e.a  = a;
    e.d  = d;
    e.pc = pc;
    sb.push_back(e);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; w_valid = 1'b0; w_addr = '0; w_data = '0; w_pc = '0;
    md_valid = 1'b0; md_addr = '0; md_data = '0; md_pc = '0; rs_addr = '0; rt_addr = '0;

    fork
      forever begin
        wr_t e;
        @(negedge clk);
        if (reset && reg_write) begin
          chk("sb_has_expect", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_addr", 32'(reg_addr), 32'(e.a));
            chk("sb_data", reg_data, e.d);
            chk("sb_pc", reg_pc, e.pc);
          end
        end
      end
    join_none

    #2;
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_reg_data", reg_data, 32'd0);
    chk("rst_reg_pc", reg_pc, 32'd0);
    chk("rst_md_ready", 32'(md_ready), 32'd1);
    chk("rst_pend_hit", 32'(pend_hit), 32'd0);
    step(); step();
    reset = 1'b1;
    step();

    // W-only write, one-cycle latency then idle with held fields
    w_valid = 1'b1; w_addr = 5'd5; w_data = 32'h1234; w_pc = 32'h100;
    expect_wr(5'd5, 32'h1234, 32'h100);
    step(); idle();
    @(negedge clk);
    chk("w_reg_write", 32'(reg_write), 32'd1);
    chk("w_reg_addr", 32'(reg_addr), 32'd5);
    chk("w_reg_data", reg_data, 32'h1234);
    step(); @(negedge clk);
    chk("w_idle_write", 32'(reg_write), 32'd0);
    chk("w_hold_addr", 32'(reg_addr), 32'd5);
    chk("w_hold_data", reg_data, 32'h1234);

    // late result bypass with empty buffer
    step();
    md_valid = 1'b1; md_addr = 5'd8; md_data = 32'hAA; md_pc = 32'h200;
    expect_wr(5'd8, 32'hAA, 32'h200);
    @(negedge clk);
    chk("byp_md_ready", 32'(md_ready), 32'd1);
    step(); idle(); @(negedge clk);
    chk("byp_reg_write", 32'(reg_write), 32'd1);
    chk("byp_reg_addr", 32'(reg_addr), 32'd8);
    chk("byp_count_zero", 32'(md_ready), 32'd1);

    // collision: W owns the port three cycles, late results fill the buffer
    for (int i = 0; i < 3; i++) expect_wr(5'd3, 32'h30 + 32'(i), 32'h300 + 32'(4 * i));
    expect_wr(5'd9,  32'hA009, 32'h400 + 32'd36);
    expect_wr(5'd10, 32'hA00A, 32'h400 + 32'd40);
    expect_wr(5'd11, 32'hA00B, 32'h400 + 32'd44);
    rs_addr = 5'd10;
    for (int i = 0; i < 5; i++) begin
      step();
      w_valid = (i < 3); w_addr = 5'd3; w_data = 32'h30 + 32'(i); w_pc = 32'h300 + 32'(4 * i);
      md_valid = 1'b1; md_addr = col_addr[i];
      md_data = 32'hA000 + 32'(col_addr[i]); md_pc = 32'h400 + 32'(col_addr[i]) * 32'd4;
      @(negedge clk);
      chk($sformatf("col_ready%0d", i), 32'(md_ready), 32'(col_rdy[i]));
      chk($sformatf("col_hit%0d", i), 32'(pend_hit), 32'(col_hit[i]));
    end
    step(); idle();
    rt_addr = 5'd11;
    repeat (3) step();
    @(negedge clk);
    chk("col_drain_hit", 32'(pend_hit), 32'd0);
    chk("col_drain_ready", 32'(md_ready), 32'd1);

    // W squashes an older buffered result to the same register
    step();
    w_valid = 1'b1; w_addr = 5'd4; w_data = 32'h44; w_pc = 32'h500;
    md_valid = 1'b1; md_addr = 5'd7; md_data = 32'h1; md_pc = 32'h504;
    rs_addr = 5'd0; rt_addr = 5'd0;
    expect_wr(5'd4, 32'h44, 32'h500);
    step();
    md_valid = 1'b0; w_addr = 5'd7; w_data = 32'h2; w_pc = 32'h508; rs_addr = 5'd7;
    expect_wr(5'd7, 32'h2, 32'h508);
    @(negedge clk);
    chk("sq_hit_before", 32'(pend_hit), 32'd1);
    step(); idle(); @(negedge clk);
    chk("sq_hit_after", 32'(pend_hit), 32'd0);
    chk("sq_reg_data", reg_data, 32'h2);
    step(); @(negedge clk);
    chk("sq_silent_pop", 32'(reg_write), 32'd0);
    chk("sq_ready", 32'(md_ready), 32'd1);

    // register 0 on both requesters
    step();
    w_valid = 1'b1; w_addr = 5'd0; w_data = 32'hDEAD; w_pc = 32'h580;
    md_valid = 1'b1; md_addr = 5'd0; md_data = 32'hBEEF; md_pc = 32'h584;
    @(negedge clk);
    chk("z_ready", 32'(md_ready), 32'd1);
    step(); idle(); @(negedge clk);
    chk("z_write", 32'(reg_write), 32'd0);
    chk("z_ready_after", 32'(md_ready), 32'd1);

    // W to $0 does not block a late bypass
    step();
    w_valid = 1'b1; w_addr = 5'd0;
    md_valid = 1'b1; md_addr = 5'd12; md_data = 32'hC; md_pc = 32'h600;
    expect_wr(5'd12, 32'hC, 32'h600);
    step(); idle(); @(negedge clk);
    chk("z_byp_write", 32'(reg_write), 32'd1);
    chk("z_byp_addr", 32'(reg_addr), 32'd12);

    // incoming late result squashed by same-cycle W
    step();
    w_valid = 1'b1; w_addr = 5'd13; w_data = 32'hD1; w_pc = 32'h700;
    md_valid = 1'b1; md_addr = 5'd13; md_data = 32'hD0; md_pc = 32'h704;
    rs_addr = 5'd13;
    expect_wr(5'd13, 32'hD1, 32'h700);
    step(); idle(); @(negedge clk);
    chk("in_sq_data", reg_data, 32'hD1);
    chk("in_sq_hit", 32'(pend_hit), 32'd0);
    step(); @(negedge clk);
    chk("in_sq_silent", 32'(reg_write), 32'd0);

    // reset with two results buffered
    step();
    w_valid = 1'b1; w_addr = 5'd3; w_data = 32'h60; w_pc = 32'h800;
    md_valid = 1'b1; md_addr = 5'd20; md_data = 32'hE0; md_pc = 32'h804;
    expect_wr(5'd3, 32'h60, 32'h800);
    step();
    w_data = 32'h61; w_pc = 32'h808;
    md_addr = 5'd21; md_data = 32'hE1; md_pc = 32'h80C;
    expect_wr(5'd3, 32'h61, 32'h808);
    step(); idle(); rs_addr = 5'd20;
    @(negedge clk);
    chk("rm_ready_full", 32'(md_ready), 32'd0);
    chk("rm_hit_full", 32'(pend_hit), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rm_write", 32'(reg_write), 32'd0);
    chk("rm_addr", 32'(reg_addr), 32'd0);
    chk("rm_ready", 32'(md_ready), 32'd1);
    chk("rm_hit", 32'(pend_hit), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rm_post_ready", 32'(md_ready), 32'd1);
    chk("rm_post_hit", 32'(pend_hit), 32'd0);
    repeat (4) step();
    @(negedge clk);
    chk("rm_post_write", 32'(reg_write), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grf_wb_arb.md
GRF_WB_ARB -- requirements
Module: grf_wb_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning late-result buffer entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port w_valid  input  1  pipeline W-stage writeback request, never back-pressured.
REQ-005 SHALL have port w_addr  input  5  W-stage destination register.
REQ-006 SHALL have port w_data  input  32  W-stage write value.
REQ-007 SHALL have port w_pc  input  32  W-stage instruction PC.
REQ-008 SHALL have port md_valid  input  1  late-result (mult/div unit) request.
REQ-009 SHALL have port md_addr / md_data / md_pc  input  5/32/32  late-result destination, value, PC.
REQ-010 SHALL have port md_ready  output  1  late result accepted this cycle when md_valid & md_ready.
REQ-011 SHALL have port rs_addr / rt_addr  input  5/5  D-stage source registers for hazard check.
REQ-012 SHALL have port pend_hit  output  1  a buffered late result targets nonzero rs_addr or rt_addr.
REQ-013 SHALL have port reg_write / reg_addr / reg_data / reg_pc  output  1/5/32/32  registered GRF write-port drive.

Function
REQ-014 SHALL drive reg_* from flops updated on rising clk only; latency request-to-reg_write is exactly 1 cycle when granted.
REQ-015 SHALL discard any request (W or late) with address 0: no output, no buffering; late one still handshakes.
REQ-016 SHALL grant W first: w_valid & w_addr!=0 produces reg_write=1 with W fields next cycle.
REQ-017 SHALL otherwise, if buffer non-empty, pop head and present it next cycle.
REQ-018 SHALL otherwise, with buffer empty, pass an accepted late result straight to next-cycle output (bypass, not buffered).
REQ-019 SHALL buffer an accepted late result not output per REQ-018, at tail, in arrival order.
REQ-020 SHALL assert md_ready = (count < DEPTH), computed from registered count only; no same-cycle pop credit.
REQ-021 SHALL, when granted W write address equals a valid buffered entry's address, squash that entry (W is newer); squashed entries are popped silently, consuming no output cycle.
REQ-022 SHALL squash also an incoming late result at tail whose address equals the same-cycle granted W address.
REQ-023 SHALL keep count in 0..DEPTH; read/write pointers wrap modulo DEPTH; full (count==DEPTH) and empty (count==0) unambiguous.
REQ-024 SHALL handle simultaneous push and pop: count unchanged, both pointers advance.
REQ-025 SHALL compute pend_hit combinationally over valid, unsquashed entries; address 0 never hits.
REQ-026 SHALL drive reg_write=0 in any cycle with no grant; reg_addr/reg_data/reg_pc then hold previous values.

Reset
REQ-027 SHALL, while reset=0, immediately clear reg_write, reg_addr, reg_data, reg_pc to 0, count and pointers to 0, all entry valid bits to 0.
REQ-028 SHALL drop all buffered and in-flight results on reset mid-operation; md_ready=1 and pend_hit=0 the first cycle after release.

Configuration
REQ-029 SHALL, with GRF_WB_TRACE_EN defined, print on each clk edge where reg_write=1: "@<reg_pc hex>: $<reg_addr dec> <= <reg_data hex>".
REQ-030 SHALL, without GRF_WB_TRACE_EN, contain no display statements; port behaviour identical.

Verification
REQ-031 W only: w_valid=1, w_addr=5, w_data=0x1234 at t -> reg_write=1, reg_addr=5, reg_data=0x1234 at t+1; reg_write=0 at t+2.
REQ-032 Bypass: buffer empty, md_valid=1, md_addr=8, md_data=0xAA, w_valid=0 -> md_ready=1, output at t+1, count stays 0.
REQ-033 Collision/fill: W to $3 and late results to $9,$10,$11 each cycle, DEPTH=2 -> $9,$10 buffered, md_ready=0 for $11 until pop; outputs $9 then $10 in order after W stops.
REQ-034 Squash: buffered late $7=0x1, then W $7=0x2 -> reg output $7=0x2 only; $7=0x1 never written; pend_hit with rs_addr=7 falls to 0.
REQ-035 Zero reg: w_addr=0 and md_addr=0 simultaneously -> reg_write stays 0, md_ready handshake completes, count stays 0.
REQ-036 Reset mid-op: two entries buffered, reset=0 for one cycle -> reg_write=0 immediately, count=0, md_ready=1, no further writes of buffered data.
